// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-word handshake bundle between uart_rx_cfg and its consumer
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (output data, valid, frame_err, parity_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, parity_err, overrun, output ready);
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampled UART receiver with word holding register and overrun flag
// Optional per-data-bit CRC tap (crc_din/crc_en) enabled by defining UART_RX_CRC_TAP_EN.
module uart_rx_cfg #(
  parameter int TICKS_PER_BIT = 12,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
`ifdef UART_RX_CRC_TAP_EN
  output logic crc_din,
  output logic crc_en,
`endif
  uart_rx_cfg_if.master m_if
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_FULL = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_sync;
  logic                 r_prev;
  logic [1:0]           r_settle;
  logic                 r_armed;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [BW-1:0]        r_bitcnt, w_bitcnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_fe, r_pe, r_ov;
  logic                 w_rxs, w_expire, w_sample_data, w_sample_par, w_done, w_perr_calc;

  assign w_rxs    = r_sync[1];
  assign w_expire = (r_tick == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = w_expire ? '0 : r_tick - 1'b1;
    w_bitcnt_nxt  = r_bitcnt;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_armed keeps a line already low at reset release from looking like a start edge
        if (r_armed && r_prev && !w_rxs) begin
          w_state_nxt = S_START;
          w_tick_nxt  = TICK_HALF;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt  = S_DATA;
            w_tick_nxt   = TICK_FULL;
            w_bitcnt_nxt = '0;
          end
        end
      end
      S_DATA: begin
        if (w_expire) begin
          w_sample_data = 1'b1;
          w_tick_nxt    = TICK_FULL;
          if (r_bitcnt == BIT_LAST) begin
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_expire) begin
          w_sample_par = 1'b1;
          w_tick_nxt   = TICK_FULL;
          w_state_nxt  = S_STOP;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_perr_calc = 1'b0;
    if (PARITY == 1) w_perr_calc = ~(^r_shift ^ w_rxs);
    if (PARITY == 2) w_perr_calc = ^r_shift ^ w_rxs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_sync   <= 2'b11;
      r_prev   <= 1'b1;
      r_settle <= '0;
      r_armed  <= 1'b0;
      r_shift  <= '0;
      r_perr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sync   <= {r_sync[0], rx};
      r_prev   <= w_rxs;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      r_armed  <= r_armed | ((r_settle == 2'd3) && w_rxs);
      if (w_sample_data) r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      if (w_sample_par) r_perr <= w_perr_calc;
    end
  end

  // A word is only replaced when the consumer is taking the old one this same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (w_done) begin
      if (r_valid && !m_if.ready) begin
        r_ov <= 1'b1;
      end else begin
        r_data  <= r_shift;
        r_fe    <= ~w_rxs;
        r_pe    <= (PARITY != 0) ? r_perr : 1'b0;
        r_valid <= 1'b1;
        r_ov    <= 1'b0;
      end
    end else if (r_valid && m_if.ready) begin
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ov    <= 1'b0;
    end
  end

  assign m_if.data       = r_data;
  assign m_if.valid      = r_valid;
  assign m_if.frame_err  = r_fe;
  assign m_if.parity_err = r_pe;
  assign m_if.overrun    = r_ov;

`ifdef UART_RX_CRC_TAP_EN
  logic r_crc_en, r_crc_din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc_en  <= 1'b0;
      r_crc_din <= 1'b0;
    end else begin
      r_crc_en <= w_sample_data;
      if (w_sample_data) r_crc_din <= w_rxs;
    end
  end

  assign crc_en  = r_crc_en;
  assign crc_din = r_crc_din;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed frames against a queue-based word model; CRC tap checked with UART_RX_CRC_TAP_EN
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();

`ifdef UART_RX_CRC_TAP_EN
  logic crc_din0, crc_en0, crc_din1, crc_en1;
`endif

  uart_rx_cfg #(.TICKS_PER_BIT(12), .DATA_BITS(8), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0),
`ifdef UART_RX_CRC_TAP_EN
    .crc_din(crc_din0), .crc_en(crc_en0),
`endif
    .m_if(if0)
  );

  uart_rx_cfg #(.TICKS_PER_BIT(12), .DATA_BITS(8), .PARITY(2)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1),
`ifdef UART_RX_CRC_TAP_EN
    .crc_din(crc_din1), .crc_en(crc_en1),
`endif
    .m_if(if1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic model_ov0 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n0 = 0;
  int   base;
  logic [7:0] last0_d, last1_d;
  logic last0_fe, last1_pe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word model: a frame's data/flags follow from its bits; a frame arriving while an
  // unaccepted word is held and the consumer is stalled is lost and flags overrun.
  task automatic line(input int w, input logic b);
    #1;
    if (w == 0) rx0 = b; else rx1 = b;
    repeat (12) @(posedge clk);
  endtask

  task automatic send(input int w, input logic [7:0] d, input int par, input logic pbit, input logic stop);
    exp_t e;
    int ones;
    ones = $countones(d) + int'(pbit);
    e.d  = d;
    e.fe = ~stop;
    e.pe = (par == 0) ? 1'b0 : (par == 2) ? (ones % 2 != 0) : (ones % 2 == 0);
    if (w == 0) begin
      if (!if0.ready && q0.size() > 0) model_ov0 = 1'b1;
      else q0.push_back(e);
    end else begin
      q1.push_back(e);
    end
    line(w, 1'b0);
    for (int i = 0; i < 8; i++) line(w, d[i]);
    if (par != 0) line(w, pbit);
    line(w, stop);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(name, q0.size() + q1.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (if0.valid) begin
        if (if0.ready) begin
          if (q0.size() == 0) begin
            chk("dut0_extra_word", if0.valid, 1'b0);
          end else begin
            e0 = q0.pop_front();
            chk("dut0_data", if0.data, e0.d);
            chk("dut0_frame_err", if0.frame_err, e0.fe);
            chk("dut0_parity_err", if0.parity_err, e0.pe);
            chk("dut0_overrun", if0.overrun, model_ov0);
            model_ov0 = 1'b0;
            n0++;
            last0_d  = if0.data;
            last0_fe = if0.frame_err;
          end
        end
      end else begin
        chk("dut0_idle_flags", {if0.frame_err, if0.parity_err, if0.overrun}, 3'b000);
      end
      if (if1.valid) begin
        if (q1.size() == 0) begin
          chk("dut1_extra_word", if1.valid, 1'b0);
        end else begin
          e1 = q1.pop_front();
          chk("dut1_data", if1.data, e1.d);
          chk("dut1_frame_err", if1.frame_err, e1.fe);
          chk("dut1_parity_err", if1.parity_err, e1.pe);
          last1_d  = if1.data;
          last1_pe = if1.parity_err;
        end
      end else begin
        chk("dut1_idle_flags", {if1.frame_err, if1.parity_err, if1.overrun}, 3'b000);
      end
    end
  end

`ifdef UART_RX_CRC_TAP_EN
  logic crc_q[$];
  logic [7:0] crc_v;
  always @(negedge clk) begin
    if (!reset && crc_en0) crc_q.push_back(crc_din0);
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    if0.ready = 1'b1;
    if1.ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_flags", {if0.valid, if0.frame_err, if0.parity_err, if0.overrun}, 4'b0000);
    chk("reset_data", if0.data, 8'h00);
    reset = 1'b0;
    repeat (8) @(posedge clk);

    base = n0;
    send(0, 8'hA5, 0, 1'b0, 1'b1);
    drain("a5_drained");
    chk("a5_count", n0 - base, 1);
    chk("a5_data", last0_d, 8'hA5);
    chk("a5_frame_err", last0_fe, 1'b0);

    send(1, 8'h37, 2, 1'b0, 1'b1);
    drain("par_bad_drained");
    chk("par_bad_data", last1_d, 8'h37);
    chk("par_bad_pe", last1_pe, 1'b1);
    send(1, 8'h37, 2, 1'b1, 1'b1);
    drain("par_good_drained");
    chk("par_good_pe", last1_pe, 1'b0);

    base = n0;
    #1 rx0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (24) @(posedge clk);
    chk("glitch_no_word", n0 - base, 0);
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    drain("glitch_then_5a_drained");
    chk("glitch_then_5a_data", last0_d, 8'h5A);

    base = n0;
    send(0, 8'h11, 0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    line(0, 1'b1);
    line(0, 1'b1);
    send(0, 8'h22, 0, 1'b0, 1'b1);
    drain("frame_err_drained");
    chk("frame_err_count", n0 - base, 2);
    chk("frame_err_last_data", last0_d, 8'h22);
    chk("frame_err_last_fe", last0_fe, 1'b0);

    #1 if0.ready = 1'b0;
    send(0, 8'h01, 0, 1'b0, 1'b1);
    send(0, 8'h02, 0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_valid", if0.valid, 1'b1);
    chk("ovr_data", if0.data, 8'h01);
    chk("ovr_flag", if0.overrun, 1'b1);
    if0.ready = 1'b1;
    @(posedge clk);
    #1 if0.ready = 1'b0;
    chk("ovr_cleared", {if0.valid, if0.overrun}, 2'b00);

    send(0, 8'h44, 0, 1'b0, 1'b1);
    line(0, 1'b0);
    line(0, 1'b1);
    line(0, 1'b1);
    line(0, 1'b0);
    chk("pre_reset_valid", if0.valid, 1'b1);
    #3 reset = 1'b1;
    rx0 = 1'b0;
    #1;
    chk("async_reset_flags", {if0.valid, if0.frame_err, if0.parity_err, if0.overrun}, 4'b0000);
    chk("async_reset_data", if0.data, 8'h00);
    q0.delete();
    model_ov0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    chk("low_line_after_reset", if0.valid, 1'b0);
    if0.ready = 1'b1;
    line(0, 1'b1);
    line(0, 1'b1);
`ifdef UART_RX_CRC_TAP_EN
    crc_q.delete();
`endif
    base = n0;
    send(0, 8'hC3, 0, 1'b0, 1'b1);
    drain("c3_drained");
    chk("c3_count", n0 - base, 1);
    chk("c3_data", last0_d, 8'hC3);
`ifdef UART_RX_CRC_TAP_EN
    chk("crc_pulses", crc_q.size(), 8);
    crc_v = 8'h00;
    for (int i = 0; i < 8; i++) if (i < crc_q.size()) crc_v[i] = crc_q[i];
    chk("crc_bits", crc_v, 8'hC3);
`endif

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 12, meaning clk cycles per bit (integer, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  DATA_BITS  received word, LSB first on the wire.
REQ-008 SHALL have port valid  output  1  data/error flags hold a word.
REQ-009 SHALL have port ready  input  1  consumer accepts the word when valid & ready.
REQ-010 SHALL have port frame_err  output  1  word's stop bit sampled low.
REQ-011 SHALL have port parity_err  output  1  word's parity mismatched; tied 0 when PARITY=0.
REQ-012 SHALL have port overrun  output  1  sticky; a word was lost while valid was high.
REQ-013 SHALL have ports crc_din and crc_en, outputs, 1 bit each, present only per REQ-030.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all further logic uses the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP with one down-counter tickcount and one bit counter.
REQ-016 IDLE: on rxs 1->0 edge (previous sample 1, current 0) SHALL enter START, tickcount = TICKS_PER_BIT/2 - 1 (integer division).
REQ-017 START: at tickcount expiry, rxs=1 SHALL return to IDLE (glitch rejected, no flags); rxs=0 SHALL enter DATA with tickcount = TICKS_PER_BIT-1.
REQ-018 DATA: each expiry SHALL shift rxs in LSB first and reload tickcount = TICKS_PER_BIT-1; after DATA_BITS samples SHALL enter PARITY if PARITY!=0, else STOP.
REQ-019 PARITY: at expiry SHALL compare rxs against XOR of data bits (odd: total ones incl. parity odd; even: even), then enter STOP.
REQ-020 STOP: at expiry SHALL complete the frame and return to IDLE; frame_err for this word = ~rxs.
REQ-021 On frame completion SHALL load data, frame_err, parity_err and assert valid on the next clk edge.
REQ-022 Frame completing while valid=1 and ready=0 SHALL discard the new word, keep the old, set overrun.
REQ-023 Frame completing in the same cycle as valid & ready SHALL load the new word, keep valid=1, not set overrun.
REQ-024 valid & ready without a completing frame SHALL clear valid, frame_err, parity_err, overrun next cycle.
REQ-025 After a framing error with rx held low SHALL not restart until a new 1->0 edge is seen.
REQ-026 rx activity outside IDLE SHALL not resynchronize the bit timing.

Reset
REQ-027 reset SHALL force state IDLE, counters 0, synchronizer and edge history to 1, data 0.
REQ-028 reset SHALL force valid, frame_err, parity_err, overrun, crc_en to 0, asynchronously, including mid-frame.
REQ-029 After reset deassertion a line already low SHALL not be taken as a start bit.

Configuration
REQ-030 With UART_RX_CRC_TAP_EN defined SHALL expose crc_din/crc_en: crc_en pulses one cycle at each DATA sample, crc_din = sampled bit; start, parity and stop bits excluded.
REQ-031 Without UART_RX_CRC_TAP_EN SHALL omit crc_din/crc_en ports and their logic; all other behaviour identical.

Verification
REQ-032 Defaults, ready=1, send 0xA5 8N1 -> one valid pulse, data=0xA5, frame_err=0, parity_err=0, overrun=0.
REQ-033 PARITY=2, send 0x37 with parity bit 0 (wrong) -> data=0x37, parity_err=1; with parity bit 1 -> parity_err=0.
REQ-034 rx low for 3 clks then high (TICKS_PER_BIT=12) -> no valid, state back in IDLE; then 0x5A -> data=0x5A.
REQ-035 Send 0x11 with stop bit low, line held low 40 clks, then high, then 0x22 -> 0x11 with frame_err=1, then 0x22 with frame_err=0, no extra word.
REQ-036 ready=0, send 0x01 then 0x02 -> data=0x01, overrun=1; assert ready one cycle -> valid=0, overrun=0.
REQ-037 Assert reset mid-DATA of a frame -> all outputs 0 immediately; next full frame 0xC3 received correctly; with UART_RX_CRC_TAP_EN, 8 crc_en pulses, crc_din = 1,1,0,0,0,0,1,1.
